// File: rtl/rect_fill_writer.sv
// rect_fill_writer: walks the tiles covered by one fill rectangle and emits one masked tile write per cycle; defining RECT_FILL_PXL_COUNT_EN adds the pxl_count output
module rect_fill_writer #(
    parameter int RESOLUTION_X = 400,
    parameter int RESOLUTION_Y = 300,
    parameter int PXL_BITS     = 8,
    parameter int TILE_WIDTH   = 4,
    parameter int TILE_HEIGHT  = 4,
    localparam int PXLS_PER_DATA = 4,
    localparam int PXL_PER_TILE  = TILE_WIDTH * TILE_HEIGHT,
    localparam int TILES_X       = RESOLUTION_X / TILE_WIDTH,
    localparam int BYTES_PER_PXL = (PXL_BITS + 7) / 8,
    localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y / PXL_PER_TILE * BYTES_PER_PXL),
    localparam int XW = $clog2(RESOLUTION_X) + 1,
    localparam int YW = $clog2(RESOLUTION_Y) + 1
) (
    input  logic                                                     wr_clk,
    input  logic                                                     wr_reset_n,
    input  logic                                                     cmd_valid,
    output logic                                                     cmd_ready,
    input  logic [XW-1:0]                                            cmd_x0,
    input  logic [XW-1:0]                                            cmd_x1,
    input  logic [YW-1:0]                                            cmd_y0,
    input  logic [YW-1:0]                                            cmd_y1,
    input  logic [PXL_BITS-1:0]                                      cmd_color,
    output logic                                                     busy,
    output logic                                                     done,
    output logic [PXL_PER_TILE-1:0][AW-1:0]                          wr_tile_index,
    output logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0][PXL_BITS-1:0] wr_pxl_data,
`ifdef RECT_FILL_PXL_COUNT_EN
    output logic [31:0]                                              pxl_count,
`endif
    output logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0]               wr_en
);
    localparam int TWL = $clog2(TILE_WIDTH);
    localparam int THL = $clog2(TILE_HEIGHT);
    localparam int LW  = $clog2(PXLS_PER_DATA);
    localparam logic [XW-1:0] X_MAX = XW'(RESOLUTION_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(RESOLUTION_Y - 1);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t                                  state_q;
    logic [XW-1:0]                           x0_q, x1_q, tx_q, tx0_q, tx1_q, x1c, px;
    logic [YW-1:0]                           y0_q, y1_q, ty_q, ty1_q, y1c, py;
    logic [PXL_BITS-1:0]                     color_q, data_q;
    logic                                    cmd_ready_q, busy_q, done_q;
    logic [AW-1:0]                           idx_d, idx_q;
    logic [PXL_PER_TILE-1:0][PXLS_PER_DATA-1:0] en_d, en_q;
`ifdef RECT_FILL_PXL_COUNT_EN
    logic [31:0]                             count_q, cnt_d;
    assign pxl_count = count_q;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign wr_en         = en_q;
    assign wr_tile_index = {PXL_PER_TILE{idx_q}};
    assign wr_pxl_data   = {PXL_PER_TILE * PXLS_PER_DATA{data_q}};

    // Clamped bounds, current tile address and per-bank coverage mask for the tile under the counters
    always_comb begin
        x1c   = x1_q > X_MAX ? X_MAX : x1_q;
        y1c   = y1_q > Y_MAX ? Y_MAX : y1_q;
        idx_d = AW'(ty_q) * AW'(TILES_X) + AW'(tx_q);
        en_d  = '0;
        px    = '0;
        py    = '0;
`ifdef RECT_FILL_PXL_COUNT_EN
        cnt_d = '0;
`endif
        for (int i = 0; i < PXL_PER_TILE; i++) begin
            px      = XW'(tx_q * TILE_WIDTH + i % TILE_WIDTH);
            py      = YW'(ty_q * TILE_HEIGHT + i / TILE_WIDTH);
            en_d[i] = (px >= x0_q && px <= x1_q && py >= y0_q && py <= y1_q) ? PXLS_PER_DATA'(1) << idx_d[LW-1:0] : '0;
`ifdef RECT_FILL_PXL_COUNT_EN
            cnt_d   = cnt_d + 32'(en_d[i] != '0);
`endif
        end
    end

    // Command FSM with registered handshake, status and write-port outputs
    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            tx_q        <= '0;
            tx0_q       <= '0;
            tx1_q       <= '0;
            ty_q        <= '0;
            ty1_q       <= '0;
            color_q     <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            en_q        <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RECT_FILL_PXL_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            done_q      <= state_q == DONE;
            en_q        <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= !(cmd_valid && cmd_ready_q);
                    busy_q      <= cmd_valid && cmd_ready_q;
                    if (cmd_valid && cmd_ready_q) begin
                        x0_q    <= cmd_x0;
                        x1_q    <= cmd_x1;
                        y0_q    <= cmd_y0;
                        y1_q    <= cmd_y1;
                        color_q <= cmd_color;
                        state_q <= SETUP;
`ifdef RECT_FILL_PXL_COUNT_EN
                        count_q <= '0;
`endif
                    end
                end
                SETUP: begin
                    x1_q    <= x1c;
                    y1_q    <= y1c;
                    tx_q    <= x0_q >> TWL;
                    tx0_q   <= x0_q >> TWL;
                    tx1_q   <= x1c >> TWL;
                    ty_q    <= y0_q >> THL;
                    ty1_q   <= y1c >> THL;
                    state_q <= (x0_q > x1c || y0_q > y1c) ? DONE : FILL;
                end
                FILL: begin
                    en_q    <= en_d;
                    idx_q   <= idx_d;
                    data_q  <= color_q;
                    tx_q    <= tx_q == tx1_q ? tx0_q : tx_q + 1'b1;
                    ty_q    <= tx_q == tx1_q ? ty_q + 1'b1 : ty_q;
                    state_q <= (tx_q == tx1_q && ty_q == ty1_q) ? DONE : FILL;
`ifdef RECT_FILL_PXL_COUNT_EN
                    count_q <= count_q + cnt_d;
`endif
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule
